stream_rescale_arb: RTL and testbench

Packet-granular round-robin arbiter that shares one `stream_rescale` input port between `N_SRC` AXI4-Stream sources. It selects one source with a pending packet and holds the grant until that packet's `tlast` beat is accepted. The selected beats then pass through a single output register into the rescaler. It sits directly in front of `stream_rescale`, and its data/keep layout matches that block's slave port.

---
 rtl/stream_rescale_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/stream_rescale_arb.sv | 129 ++++++++++++
 tb/tb_stream_rescale_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rescale_pkg.sv
// rtl/stream_rescale_pkg.sv - shared types and round-robin helper for stream_rescale_arb
//
// Contents:
//   arb_state_t  arbiter FSM encoding (IDLE: no grant, BUSY: packet in progress)
//   RR_MAX_REQ   widest request vector rr_pick can search
//   rr_pick      first set request searching cyclically from last+1 (mod n)
package stream_rescale_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam int unsigned RR_MAX_REQ = 32;

   // Returns 'last' when no request is set, so callers can leave the pointer
   // untouched. The loop bound is a constant so the search unrolls cleanly.
   function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                           input int unsigned           last,
                                           input int unsigned           n);
      int unsigned idx;
      logic        found;
      rr_pick = last;
      found   = 1'b0;
      idx     = last;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         if (k < n) begin
            idx = (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
            if (!found && req[idx]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over a request vector
//
// Ports:
//   req   in   N           request vector
//   last  in   clog2(N)    previously granted index (search starts at last+1)
//   any   out  1           at least one request set
//   pick  out  clog2(N)    winning index, equals last when no request is set
module rr_arbiter
   import stream_rescale_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic                 any,
   output logic [$clog2(N)-1:0] pick
);

   localparam int IW = $clog2(N);

   logic [RR_MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      any            = |req;
      pick           = IW'(rr_pick(req_ext, 32'(last), N));
   end

endmodule

// File: rtl/stream_rescale_arb.sv
// rtl/stream_rescale_arb.sv - packet-granular round-robin arbiter in front of stream_rescale
//
// Optional feature macro: STREAM_RESCALE_ARB_ID_EN (adds m_id_o, the source
// index registered with each output beat).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   s_data_i     [N_SRC][KEEP_WIDTH][T_DATA_WIDTH] per-source lane data
//   s_keep_i     [N_SRC][KEEP_WIDTH] per-source lane enables
//   s_tlast_i    [N_SRC] per-source end of packet
//   s_valid_i    [N_SRC] per-source valid
//   s_ready_o    [N_SRC] per-source ready (only the granted bit can be set)
//   m_data_o     [KEEP_WIDTH][T_DATA_WIDTH] registered beat to the rescaler
//   m_keep_o     [KEEP_WIDTH] registered lane enables
//   m_tlast_o    registered end of packet
//   m_valid_o    output valid
//   m_ready_i    rescaler ready
//   busy_o       packet in progress
//   grant_o      current or last granted source
//   m_id_o       (macro only) source index of the beat on m_*
module stream_rescale_arb
   import stream_rescale_pkg::*;
#(
   parameter int N_SRC        = 4,
   parameter int T_DATA_WIDTH = 4,
   parameter int KEEP_WIDTH   = 4
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [N_SRC-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [N_SRC-1:0][KEEP_WIDTH-1:0]                 s_keep_i,
   input  logic [N_SRC-1:0]                                 s_tlast_i,
   input  logic [N_SRC-1:0]                                 s_valid_i,
   output logic [N_SRC-1:0]                                 s_ready_o,
   output logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]          m_data_o,
   output logic [KEEP_WIDTH-1:0]                            m_keep_o,
   output logic                                             m_tlast_o,
   output logic                                             m_valid_o,
   input  logic                                             m_ready_i,
   output logic                                             busy_o,
   output logic [$clog2(N_SRC)-1:0]                         grant_o
`ifdef STREAM_RESCALE_ARB_ID_EN
   ,
   output logic [$clog2(N_SRC)-1:0]                         m_id_o
`endif
);

   localparam int GW = $clog2(N_SRC);

   arb_state_t state, state_nxt;
   logic       req_any;
   logic [GW-1:0] req_pick;
   logic       out_free;
   logic       in_accept;

   rr_arbiter #(.N(N_SRC)) u_rr (
      .req  (s_valid_i),
      .last (grant_o),
      .any  (req_any),
      .pick (req_pick)
   );

   // The output register can take a beat when empty or being drained this cycle.
   assign out_free  = !m_valid_o || m_ready_i;
   assign in_accept = (state == BUSY) && out_free && s_valid_i[grant_o];
   assign busy_o    = (state == BUSY);

   always_comb begin
      s_ready_o = '0;
      if ((state == BUSY) && out_free) begin
         s_ready_o[grant_o] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration only happens in IDLE, which costs one bubble per packet but
   // keeps the grant path off the tlast-accept path.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = BUSY;
         BUSY:    if (in_accept && s_tlast_i[grant_o]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reset to the last index so source 0 has first priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_o <= GW'(N_SRC - 1);
      end else if ((state == IDLE) && req_any) begin
         grant_o <= req_pick;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_keep_o  <= '0;
         m_tlast_o <= 1'b0;
      end else if (in_accept) begin
         m_valid_o <= 1'b1;
         m_data_o  <= s_data_i[grant_o];
         m_keep_o  <= s_keep_i[grant_o];
         m_tlast_o <= s_tlast_i[grant_o];
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

`ifdef STREAM_RESCALE_ARB_ID_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_id_o <= '0;
      end else if (in_accept) begin
         m_id_o <= grant_o;
      end
   end
`endif

endmodule

// File: tb/tb_stream_rescale_arb.sv
// tb/tb_stream_rescale_arb.sv - randomized scoreboard bench for stream_rescale_arb
module tb_stream_rescale_arb;

   localparam int N  = 4;
   localparam int TW = 4;
   localparam int KW = 4;
   localparam int DW = TW * KW;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      int            src;
   } beat_t;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic [N-1:0][KW-1:0][TW-1:0] s_data_i = '0;
   logic [N-1:0][KW-1:0]        s_keep_i = '0;
   logic [N-1:0]                s_tlast_i = '0;
   logic [N-1:0]                s_valid_i = '0;
   logic [N-1:0]                s_ready_o;
   logic [KW-1:0][TW-1:0]       m_data_o;
   logic [KW-1:0]               m_keep_o;
   logic                        m_tlast_o;
   logic                        m_valid_o;
   logic                        m_ready_i = 1'b1;
   logic                        busy_o;
   logic [1:0]                  grant_o;
`ifdef STREAM_RESCALE_ARB_ID_EN
   logic [1:0]                  m_id_o;
`endif

   always #5 clk = ~clk;

   stream_rescale_arb #(.N_SRC(N), .T_DATA_WIDTH(TW), .KEEP_WIDTH(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_data_i  (s_data_i),
      .s_keep_i  (s_keep_i),
      .s_tlast_i (s_tlast_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .m_data_o  (m_data_o),
      .m_keep_o  (m_keep_o),
      .m_tlast_o (m_tlast_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .busy_o    (busy_o),
      .grant_o   (grant_o)
`ifdef STREAM_RESCALE_ARB_ID_EN
      ,
      .m_id_o    (m_id_o)
`endif
   );

   beat_t drv_q [N][$];
   beat_t mdl_q [N][$];
   beat_t exp_q [$];
   int    pkt_src_q [$];
   int    model_last = N - 1;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    stall_en = 1'b0;
   int    ready_pct = 100;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add_beat(input int s, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      b.src  = s;
      drv_q[s].push_back(b);
      mdl_q[s].push_back(b);
   endtask

   task automatic add_pkt(input int s, input int len);
      for (int i = 0; i < len; i++) begin
         add_beat(s, DW'($urandom), KW'($urandom), (i == len - 1));
      end
   endtask

   // Reference: every source with a queued packet is requesting at each
   // packet boundary, so output order is plain round robin over non-empty
   // source queues, one whole packet at a time.
   task automatic model_schedule();
      int    c;
      beat_t b;
      forever begin
         c = -1;
         for (int k = 1; k <= N; k++) begin
            if (c < 0 && mdl_q[(model_last + k) % N].size() > 0) c = (model_last + k) % N;
         end
         if (c < 0) break;
         pkt_src_q.push_back(c);
         do begin
            b = mdl_q[c].pop_front();
            exp_q.push_back(b);
         end while (!b.last);
         model_last = c;
      end
   endtask

   // Drives sources and m_ready_i at the falling edge; input-side checks run
   // 1 time unit later once the combinational ready has settled.
   task automatic run_phase(input int max_cycles, input int abort_fires);
      logic [N-1:0] fire_v;
      logic [N-1:0] in_pkt;
      beat_t        b;
      bit           after_last;
      bit           exp_busy_next;
      int           cyc;
      int           nf;
      int           fs;
      fire_v = '0;
      in_pkt = '0;
      after_last = 1'b0;
      exp_busy_next = 1'b0;
      cyc = 0;
      nf = 0;
      forever begin
         @(negedge clk);
         for (int s = 0; s < N; s++) begin
            if (fire_v[s]) begin
               b = drv_q[s].pop_front();
               in_pkt[s] = !b.last;
            end
         end
         if (after_last) begin
            chk("bubble_busy", 32'(busy_o), 32'd0);
            chk("bubble_ready", 32'(s_ready_o), 32'd0);
         end
         if (exp_busy_next) chk("rearb_busy", 32'(busy_o), 32'd1);
         exp_busy_next = after_last && (pkt_src_q.size() > 0);
         after_last = 1'b0;
         if (abort_fires > 0 && nf >= abort_fires) break;
         if (exp_q.size() == 0 && pkt_src_q.size() == 0) break;
         if (cyc > max_cycles) begin
            chk("phase_timeout", 32'd1, 32'd0);
            break;
         end
         for (int s = 0; s < N; s++) begin
            if (drv_q[s].size() > 0) begin
               b = drv_q[s][0];
               s_valid_i[s] = !(in_pkt[s] && stall_en && ($urandom_range(0, 3) == 0));
               s_data_i[s]  = b.data;
               s_keep_i[s]  = b.keep;
               s_tlast_i[s] = b.last;
            end else begin
               s_valid_i[s] = 1'b0;
               s_data_i[s]  = DW'($urandom);
               s_keep_i[s]  = KW'($urandom);
               s_tlast_i[s] = 1'($urandom);
            end
         end
         m_ready_i = ($urandom_range(0, 99) < ready_pct);
         #1;
         fire_v = s_valid_i & s_ready_o;
         if (m_valid_o && !m_ready_i) chk("stall_ready", 32'(s_ready_o), 32'd0);
         if (fire_v != '0) begin
            chk("fire_onehot", 32'($countones(fire_v)), 32'd1);
            fs = 0;
            for (int s = 0; s < N; s++) if (fire_v[s]) fs = s;
            if (pkt_src_q.size() == 0) begin
               chk("fire_unexpected", 32'd1, 32'd0);
            end else begin
               chk("fire_src", 32'(fs), 32'(pkt_src_q[0]));
               chk("grant_o", 32'(grant_o), 32'(pkt_src_q[0]));
               if (drv_q[fs][0].last) begin
                  void'(pkt_src_q.pop_front());
                  after_last = 1'b1;
               end
            end
            nf++;
         end
         cyc++;
      end
   endtask

   // Monitor: pops the scoreboard on each output handshake and checks that
   // m_* holds steady while stalled.
   initial begin
      bit            prev_stall;
      logic [DW-1:0] pd;
      logic [KW-1:0] pk;
      logic          pl;
      beat_t         e;
`ifdef STREAM_RESCALE_ARB_ID_EN
      logic [1:0]    pid;
      pid = '0;
`endif
      prev_stall = 1'b0;
      pd = '0;
      pk = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_data", 32'(m_data_o), 32'(pd));
            chk("hold_keep", 32'(m_keep_o), 32'(pk));
            chk("hold_tlast", 32'(m_tlast_o), 32'(pl));
`ifdef STREAM_RESCALE_ARB_ID_EN
            chk("hold_id", 32'(m_id_o), 32'(pid));
`endif
         end
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(m_data_o), 32'(e.data));
               chk("out_keep", 32'(m_keep_o), 32'(e.keep));
               chk("out_tlast", 32'(m_tlast_o), 32'(e.last));
`ifdef STREAM_RESCALE_ARB_ID_EN
               chk("out_id", 32'(m_id_o), 32'(e.src));
`endif
            end
         end
         prev_stall = m_valid_o && !m_ready_i;
         pd = m_data_o;
         pk = m_keep_o;
         pl = m_tlast_o;
`ifdef STREAM_RESCALE_ARB_ID_EN
         pid = m_id_o;
`endif
      end
   end

   initial begin
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_m_valid", 32'(m_valid_o), 32'd0);
      chk("rst_m_data", 32'(m_data_o), 32'd0);
      chk("rst_m_keep", 32'(m_keep_o), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_s_ready", 32'(s_ready_o), 32'd0);
      chk("rst_grant", 32'(grant_o), 32'(N - 1));
      rst = 1'b0;

      // Single source 2, three beats with shrinking keep.
      add_beat(2, DW'($urandom), 4'b1111, 1'b0);
      add_beat(2, DW'($urandom), 4'b0011, 1'b0);
      add_beat(2, DW'($urandom), 4'b0001, 1'b1);
      model_schedule();
      stall_en = 1'b0;
      ready_pct = 100;
      run_phase(100, 0);
      chk("grant_after_single", 32'(grant_o), 32'd2);

      // All sources with back-to-back 2-beat packets, no backpressure.
      for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_pkt(s, 2);
      model_schedule();
      run_phase(300, 0);

      // Random packets, random backpressure and mid-packet valid drops.
      stall_en = 1'b1;
      ready_pct = 70;
      for (int i = 0; i < 30; i++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
      model_schedule();
      run_phase(3000, 0);

      // Sources 1 and 3 interleaving under heavy backpressure.
      ready_pct = 40;
      for (int i = 0; i < 6; i++) begin
         add_pkt(1, 3);
         add_pkt(3, 2);
      end
      model_schedule();
      run_phase(3000, 0);

      // Asynchronous reset in the middle of a packet, away from any edge.
      stall_en = 1'b0;
      ready_pct = 100;
      add_pkt(0, 4);
      add_pkt(1, 2);
      model_schedule();
      run_phase(100, 2);
      #3 rst = 1'b1;
      #1;
      chk("arst_m_valid", 32'(m_valid_o), 32'd0);
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_s_ready", 32'(s_ready_o), 32'd0);
      chk("arst_grant", 32'(grant_o), 32'(N - 1));
      for (int s = 0; s < N; s++) begin
         drv_q[s].delete();
         mdl_q[s].delete();
      end
      exp_q.delete();
      pkt_src_q.delete();
      model_last = N - 1;
      s_valid_i = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int s = N - 1; s >= 0; s--) add_pkt(s, 1);
      model_schedule();
      run_phase(200, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
